// File: rtl/shift_pkg.sv
// Shared constants for the shifter datapath and its output FIFO.
// Defaults here size the FIFO; the shifter op encoding lives alongside.
package shift_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 4;
    localparam int TAG_W     = 5;
    localparam int PTR_W     = $clog2(DEPTH_DEF);
    localparam int SHAMT_W   = 3;

    // Tag layout: {lr, al, shamt}
    localparam int TAG_LR = 4;
    localparam int TAG_AL = 3;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b10,
        SH_SRA = 2'b11
    } shift_op_e;

    function automatic logic [TAG_W-1:0] mk_tag(
        input logic lr,
        input logic al,
        input logic [SHAMT_W-1:0] shamt
    );
        return {lr, al, shamt};
    endfunction

endpackage

// File: rtl/shift_out_ptr.sv
// Wrapping FIFO pointer: advances on en, returns to 0 after DEPTH-1.
module shift_out_ptr #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [AW-1:0] ptr
);

    logic [AW-1:0] ptr_nxt;

    always_comb begin
        ptr_nxt = ptr;
        if (en) begin
            if (ptr == AW'(DEPTH - 1))
                ptr_nxt = '0;
            else
                ptr_nxt = ptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else
            ptr <= ptr_nxt;
    end

endmodule

// File: rtl/shift_out_fifo.sv
// Register FIFO buffering shifter results with their op tags.
// Head is read straight from storage, so a push shows up a cycle later.
module shift_out_fifo
    import shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_zero,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     dropped,
    input  logic                     clr_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [TAG_W-1:0] tag_q  [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             push;
    logic             pop;
    logic [CW-1:0]    count_nxt;

    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_data = data_q[rptr];
    assign out_tag  = tag_q[rptr];
    assign out_zero = (data_q[rptr] == '0);

    shift_out_ptr #(.DEPTH(DEPTH), .AW(AW)) u_wptr (
        .clk (clk),
        .rst (rst),
        .en  (push),
        .ptr (wptr)
    );

    shift_out_ptr #(.DEPTH(DEPTH), .AW(AW)) u_rptr (
        .clk (clk),
        .rst (rst),
        .en  (pop),
        .ptr (rptr)
    );

    always_comb begin
        count_nxt = count;
        unique case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else
            count <= count_nxt;
    end

    // A rejected push outranks a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst)
            dropped <= 1'b0;
        else if (in_valid && !in_ready)
            dropped <= 1'b1;
        else if (clr_drop)
            dropped <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            data_q[wptr] <= in_data;
            tag_q[wptr]  <= in_tag;
        end
    end

endmodule

// File: tb/tb_shift_out_fifo.sv
// Directed bench for shift_out_fifo with hand-computed expectations.
module tb_shift_out_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic [4:0] in_tag;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [4:0] out_tag;
    logic       out_zero;
    logic       out_ready;
    logic [2:0] count;
    logic       dropped;
    logic       clr_drop;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    shift_out_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_zero  (out_zero),
        .out_ready (out_ready),
        .count     (count),
        .dropped   (dropped),
        .clr_drop  (clr_drop)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic [4:0] t);
        in_valid = 1'b1;
        in_data  = d;
        in_tag   = t;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_tag = '0;
        out_ready = 1'b0; clr_drop = 1'b0;
        step();
        rst = 1'b0;
        chk("rst_count", count, 0);
        chk("rst_oval", out_valid, 0);
        chk("rst_irdy", in_ready, 1);
        chk("rst_drop", dropped, 0);

        // basic flow, no bypass
        in_valid = 1'b1; in_data = 8'hA5; in_tag = 5'b10011;
        #1;
        chk("nobypass", out_valid, 0);
        step();
        in_valid = 1'b0;
        chk("b_oval", out_valid, 1);
        chk("b_data", out_data, 8'hA5);
        chk("b_tag", out_tag, 5'b10011);
        chk("b_count", count, 1);
        chk("b_zero", out_zero, 0);
        pop();
        chk("b_empty", count, 0);

        // fill and drop
        for (int i = 1; i <= 4; i++) push(8'(i), 5'(i));
        chk("f_count", count, 4);
        chk("f_irdy", in_ready, 0);
        chk("f_drop0", dropped, 0);
        push(8'h05, 5'h05);
        chk("f_count5", count, 4);
        chk("f_drop1", dropped, 1);
        chk("f_head", out_data, 8'h01);

        // full with simultaneous push and pop: pop only
        in_valid = 1'b1; in_data = 8'h66; out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("s_count", count, 3);
        chk("s_drop", dropped, 1);
        for (int i = 2; i <= 4; i++) begin
            chk("s_order", out_data, 32'(i));
            chk("s_otag", out_tag, 32'(i));
            pop();
        end
        chk("s_empty", count, 0);
        chk("s_oval", out_valid, 0);
        pop();
        chk("e_nounder", count, 0);

        // zero flag and clear
        clr_drop = 1'b1; step(); clr_drop = 1'b0;
        chk("c_clr", dropped, 0);
        push(8'h00, 5'h00);
        chk("z_oval", out_valid, 1);
        chk("z_zero", out_zero, 1);
        pop();
        for (int i = 0; i < 4; i++) push(8'h20 + 8'(i), 5'h1);
        push(8'hEE, 5'h1);
        chk("c_drop", dropped, 1);
        in_valid = 1'b1; clr_drop = 1'b1;
        step();
        in_valid = 1'b0; clr_drop = 1'b0;
        chk("c_setwins", dropped, 1);

        // mid-stream reset at count 3, with push and pop offered
        pop();
        chk("r_count3", count, 3);
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("r_count", count, 0);
        chk("r_oval", out_valid, 0);
        chk("r_irdy", in_ready, 1);
        chk("r_drop", dropped, 0);
        push(8'h77, 5'h7);
        chk("r_fresh", out_data, 8'h77);
        pop();

        // wrap: 10 push/pop pairs
        rst = 1'b1; step(); rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                chk("w_data", out_data, 32'h10 + 32'(i - 1));
                chk("w_tag", out_tag, 32'(i - 1));
            end
            in_valid = 1'b1; in_data = 8'h10 + 8'(i); in_tag = 5'(i);
            step();
            chk("w_count", count, 1);
        end
        in_valid = 1'b0;
        chk("w_last", out_data, 8'h19);
        step();
        out_ready = 1'b0;
        chk("w_empty", count, 0);
        chk("w_drop", dropped, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
